uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the 8N1 receiver on the DE10-Lite peripherals bus. Converts serial line data to parallel words.
- Configurable data width, parity mode and stop-bit count.
- Synchronises the asynchronous RX pin.
- Flags parity and framing errors, and suppresses false starts during line break.
- Sits between the board RX pin and the consumer logic (LED/7-seg display, FIFO).

Parameters:
CLKS_PER_BIT, 434, clocks per bit (i_Clock freq / baud); must be >= 8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
i_Clock  in  1  system clock, 50 MHz
i_Rst_n  in  1  asynchronous active-low reset
i_RX_Serial  in  1  asynchronous serial line, idle high
o_RX_DV  out  1  one-cycle pulse: word complete (valid, or with error flags set)
o_RX_Data  out  DATA_BITS  received word, held until next o_RX_DV
o_Parity_Err  out  1  parity mismatch on the word flagged by o_RX_DV; held with o_RX_Data
o_Frame_Err  out  1  stop bit sampled low on that word; held with o_RX_Data
o_Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low: one clock; reset is asynchronous and active-low.
  - While reset is asserted: all outputs 0, state IDLE, counters 0, synchroniser flops 1.
  - Reset asserted mid-frame aborts the frame with no o_RX_DV.
- Synchroniser: 2-flop chain on i_RX_Serial; all logic uses the synchronised value s.
- Clock counter width is $clog2(CLKS_PER_BIT). H = (CLKS_PER_BIT-1)/2, C = CLKS_PER_BIT.
- N = DATA_BITS + (PARITY != 0) + STOP_BITS.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: s == 0 at cycle t0 -> START with count 0.
  - START: increment count until count == H, then sample.
    - Sample 0 -> DATA, count 0.
    - Sample 1 -> IDLE (glitch rejected, no DV).
  - DATA: count 0..C-1; sample at count == C-1 into bit index, LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: one sample at count == C-1.
    - Odd mode: error if XOR(data, parity bit) == 0.
    - Even mode: error if XOR(data, parity bit) == 1.
  - STOP: sample each stop bit at count == C-1. Frame error if any stop sample is 0.
- Completion:
  - o_RX_DV is high exactly at cycle t0 + 2 + H + N*C.
  - o_RX_Data, o_Parity_Err and o_Frame_Err update in that same cycle.
- After DV:
  - No frame error -> IDLE.
  - Frame error -> WAIT_IDLE. Remain there until s == 1, then IDLE. A break condition therefore yields exactly one DV and no repeated starts.
- o_Parity_Err is 0 when PARITY == 0.
- DATA_BITS < 8: unused bits do not exist. The output is exactly DATA_BITS wide.
- Back-to-back frames: a start bit immediately after the stop midpoint is accepted; no dead cycles beyond the DV cycle.

Optional Feature:
Macro: UART_RX_MAJORITY_EN
- Defined: a 3-deep history of s is kept. Every bit sample (start, data, parity, stop) takes the majority of s at count-2, count-1 and the sample count. No added latency.
- Not defined: single sample of s at the sample count.
- The same DV timing applies in both builds.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0xA5, frame clean -> o_RX_DV pulses once at t0+153, o_RX_Data=0xA5, both error flags 0.
2. PARITY=2 (even), send 0x07 with parity bit 1 -> DV with o_Parity_Err=0. Resend with parity bit 0 -> o_Parity_Err=1, o_RX_Data=0x07.
3. STOP_BITS=2, second stop bit driven 0 -> DV with o_Frame_Err=1. Hold line low 40 bit-times -> no further DV. Return line high, then send 0x3C -> o_RX_DV with 0x3C, o_Frame_Err=0.
4. Low glitch of 5 clocks on an idle line -> no DV; o_Busy high during START only, then back to IDLE.
5. Deassert i_Rst_n during bit 4 of a frame -> outputs 0 immediately. Release reset, then send 0x5A -> received correctly.
6. With UART_RX_MAJORITY_EN: single-clock low glitch at the midpoint of a 1 data bit -> bit read as 1. Without the macro, the same stimulus -> bit read as 0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver. Frame = start bit, DATA_BITS data bits (LSB first),
// optional odd/even parity bit, STOP_BITS stop bits. The RX pin passes through a 2-flop
// synchroniser; every bit is sampled on a counter aligned to the middle of the start bit.
// Build option: define UART_RX_MAJORITY_EN to vote each bit sample over three consecutive
// synchronised values instead of taking a single one.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic                 sync_meta, s;
  logic                 bit_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 last_cnt;
  logic                 ferr_nxt;
  logic                 par_x;

  // Two-flop synchroniser; idle-high line, so flops reset to 1.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_meta <= 1'b1;
      s         <= 1'b1;
    end else begin
      sync_meta <= i_RX_Serial;
      s         <= sync_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_d1, s_d2;

  // History of s one and two cycles back, so the vote covers count-2..count.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s_d1 <= 1'b1;
      s_d2 <= 1'b1;
    end else begin
      s_d1 <= s;
      s_d2 <= s_d1;
    end
  end

  assign bit_s = (s & s_d1) | (s & s_d2) | (s_d1 & s_d2);
`else
  assign bit_s = s;
`endif

  assign last_cnt = (cnt_q == LAST_CNT);
  assign ferr_nxt = ferr_q | ~bit_s;
  assign par_x    = (^shreg_q) ^ bit_s;

  // Next-state logic: bit timing, shifting, error accumulation and word completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    case (state_q)
      S_IDLE: begin
        if (!s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          // A high sample here is a glitch, not a start bit.
          state_d = bit_s ? S_IDLE : S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (last_cnt) begin
          cnt_d   = '0;
          shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (last_cnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = (PARITY == 1) ? ~par_x : par_x;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d      = '0;
            dv_d       = 1'b1;
            data_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_nxt;
            // After a framing error wait for the line to return high (break handling).
            state_d    = ferr_nxt ? S_WAIT_IDLE : S_IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            ferr_d = ferr_nxt;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Data    = data_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule
